// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the hazard controller (slave).
// The master supplies ID decode and ID/EX buffer fields; the slave returns buffer enables and status.
interface pipeline_hazard_controller_if #(
    parameter int REG_ADDR_W = 4
);
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic                  id_halt;
    logic                  idex_mem_read;
    logic [REG_ADDR_W-1:0] idex_rd;
    logic                  idex_mul_start;
    logic                  idex_div_start;
    logic                  ex_branch_taken;
    logic                  pc_write;
    logic                  ifid_write;
    logic                  ifid_flush;
    logic                  idex_write;
    logic                  idex_flush;
    logic                  exmem_bubble;
    logic                  mdu_busy;
    logic                  mdu_done;
    logic                  halted;
    logic [15:0]           stall_count;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_halt,
        output idex_mem_read, idex_rd, idex_mul_start, idex_div_start, ex_branch_taken,
        input  pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
        input  exmem_bubble, mdu_busy, mdu_done, halted, stall_count
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_halt,
        input  idex_mem_read, idex_rd, idex_mul_start, idex_div_start, ex_branch_taken,
        output pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
        output exmem_bubble, mdu_busy, mdu_done, halted, stall_count
    );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// 5-stage pipeline hazard sequencer: load-use stalls, branch flushes, multi-cycle MDU occupancy
// of EX and HALT drain, with a saturating stall-cycle counter for debug.
module pipeline_hazard_controller #(
    parameter int REG_ADDR_W = 4,
    parameter int MUL_CYCLES = 3,
    parameter int DIV_CYCLES = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    pipeline_hazard_controller_if.slave  hz
);
    localparam int CNT_W = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_MDU  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    // Load value excludes the start cycle and the final (done) cycle.
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 2);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);

    logic [1:0]       state_r;
    logic [1:0]       next_state_s;
    logic [CNT_W-1:0] mdu_cnt_r;
    logic [CNT_W-1:0] next_cnt_s;
    logic [15:0]      stall_count_r;

    logic load_use_s;
    logic mdu_start_s;
    logic pc_write_s;
    logic ifid_write_s;
    logic ifid_flush_s;
    logic idex_write_s;
    logic idex_flush_s;
    logic exmem_bubble_s;
    logic mdu_busy_s;
    logic mdu_done_s;
    logic halted_s;

    assign load_use_s = hz.idex_mem_read
                      && (hz.idex_rd != {REG_ADDR_W{1'b0}})
                      && ((hz.id_use_rs1 && (hz.id_rs1 == hz.idex_rd))
                       || (hz.id_use_rs2 && (hz.id_rs2 == hz.idex_rd)));

    assign mdu_start_s = hz.idex_mul_start || hz.idex_div_start;

    // Control outputs and next state from current state plus hazard inputs, in priority order.
    always_comb begin
        pc_write_s     = 1'b1;
        ifid_write_s   = 1'b1;
        ifid_flush_s   = 1'b0;
        idex_write_s   = 1'b1;
        idex_flush_s   = 1'b0;
        exmem_bubble_s = 1'b0;
        mdu_busy_s     = 1'b0;
        mdu_done_s     = 1'b0;
        halted_s       = 1'b0;
        next_state_s   = state_r;
        next_cnt_s     = mdu_cnt_r;
        case (state_r)
            ST_HALT: begin
                pc_write_s   = 1'b0;
                ifid_write_s = 1'b0;
                idex_flush_s = 1'b1;
                halted_s     = 1'b1;
            end
            ST_MDU: begin
                pc_write_s   = 1'b0;
                ifid_write_s = 1'b0;
                idex_write_s = 1'b0;
                mdu_busy_s   = 1'b1;
                if (mdu_cnt_r == {CNT_W{1'b0}}) begin
                    mdu_done_s     = 1'b1;
                    exmem_bubble_s = 1'b0;
                    next_state_s   = ST_RUN;
                end else begin
                    exmem_bubble_s = 1'b1;
                    next_cnt_s     = mdu_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_RUN: begin
                if (mdu_start_s) begin
                    pc_write_s     = 1'b0;
                    ifid_write_s   = 1'b0;
                    idex_write_s   = 1'b0;
                    exmem_bubble_s = 1'b1;
                    mdu_busy_s     = 1'b1;
                    next_state_s   = ST_MDU;
                    next_cnt_s     = hz.idex_div_start ? DIV_LOAD : MUL_LOAD;
                end else if (hz.ex_branch_taken) begin
                    ifid_flush_s = 1'b1;
                    idex_flush_s = 1'b1;
                end else if (load_use_s) begin
                    pc_write_s   = 1'b0;
                    ifid_write_s = 1'b0;
                    idex_flush_s = 1'b1;
                end else if (hz.id_halt) begin
                    next_state_s = ST_HALT;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            default: begin
                next_state_s = ST_RUN;
                next_cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, MDU countdown and saturating stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_RUN;
            mdu_cnt_r     <= {CNT_W{1'b0}};
            stall_count_r <= 16'd0;
        end else begin
            state_r   <= next_state_s;
            mdu_cnt_r <= next_cnt_s;
            if (!pc_write_s && (state_r != ST_HALT) && (stall_count_r != 16'hFFFF)) begin
                stall_count_r <= stall_count_r + 16'd1;
            end else begin
                stall_count_r <= stall_count_r;
            end
        end
    end

    assign hz.pc_write     = pc_write_s;
    assign hz.ifid_write   = ifid_write_s;
    assign hz.ifid_flush   = ifid_flush_s;
    assign hz.idex_write   = idex_write_s;
    assign hz.idex_flush   = idex_flush_s;
    assign hz.exmem_bubble = exmem_bubble_s;
    assign hz.mdu_busy     = mdu_busy_s;
    assign hz.mdu_done     = mdu_done_s;
    assign hz.halted       = halted_s;
    assign hz.stall_count  = stall_count_r;
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: a cycle-level behavioural model is checked against
// every output at each negedge, and literal expectations pin the key scenarios.
module tb_pipeline_hazard_controller;
    localparam int MUL_N = 3;
    localparam int DIV_N = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pipeline_hazard_controller_if #(.REG_ADDR_W(4)) hz_if ();

    pipeline_hazard_controller #(
        .REG_ADDR_W(4),
        .MUL_CYCLES(MUL_N),
        .DIV_CYCLES(DIV_N)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz_if)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Model state: remaining MDU cycles after the current one, halt flag, stall count.
    int mdu_left = 0;
    bit halt_m   = 1'b0;
    int stall_m  = 0;
    bit armed    = 1'b0;

    task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic lit(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        cmp(nm, act, exp);
    endtask

    // Per-cycle model comparison, then advance the model as the coming edge will.
    always @(negedge clk) begin
        bit e_pc, e_ifw, e_ifl, e_idw, e_idf, e_bub, e_busy, e_done, e_halt, lu, start;
        lu = hz_if.idex_mem_read && (hz_if.idex_rd != 4'd0) &&
             ((hz_if.id_use_rs1 && hz_if.id_rs1 == hz_if.idex_rd) ||
              (hz_if.id_use_rs2 && hz_if.id_rs2 == hz_if.idex_rd));
        start = hz_if.idex_mul_start || hz_if.idex_div_start;
        e_pc = 1; e_ifw = 1; e_idw = 1; e_ifl = 0; e_idf = 0;
        e_bub = 0; e_busy = 0; e_done = 0; e_halt = 0;
        if (halt_m) begin
            e_pc = 0; e_ifw = 0; e_idf = 1; e_halt = 1;
        end else if (mdu_left > 0) begin
            e_pc = 0; e_ifw = 0; e_idw = 0; e_busy = 1;
            e_done = (mdu_left == 1);
            e_bub  = (mdu_left != 1);
        end else if (start) begin
            e_pc = 0; e_ifw = 0; e_idw = 0; e_busy = 1; e_bub = 1;
        end else if (hz_if.ex_branch_taken) begin
            e_ifl = 1; e_idf = 1;
        end else if (lu) begin
            e_pc = 0; e_ifw = 0; e_idf = 1;
        end
        if (armed) begin
            n_vec++;
            cmp("pc_write",     {15'd0, hz_if.pc_write},     {15'd0, e_pc});
            cmp("ifid_write",   {15'd0, hz_if.ifid_write},   {15'd0, e_ifw});
            cmp("ifid_flush",   {15'd0, hz_if.ifid_flush},   {15'd0, e_ifl});
            cmp("idex_write",   {15'd0, hz_if.idex_write},   {15'd0, e_idw});
            cmp("idex_flush",   {15'd0, hz_if.idex_flush},   {15'd0, e_idf});
            cmp("exmem_bubble", {15'd0, hz_if.exmem_bubble}, {15'd0, e_bub});
            cmp("mdu_busy",     {15'd0, hz_if.mdu_busy},     {15'd0, e_busy});
            cmp("mdu_done",     {15'd0, hz_if.mdu_done},     {15'd0, e_done});
            cmp("halted",       {15'd0, hz_if.halted},       {15'd0, e_halt});
            cmp("stall_count",  hz_if.stall_count,           stall_m[15:0]);
        end
        if (rst) begin
            mdu_left = 0; halt_m = 0; stall_m = 0; armed = 1'b1;
        end else begin
            if (!e_pc && !halt_m && stall_m < 65535) stall_m++;
            if (!halt_m) begin
                if (mdu_left > 0) mdu_left--;
                else if (start) mdu_left = (hz_if.idex_div_start ? DIV_N : MUL_N) - 1;
                else if (!hz_if.ex_branch_taken && !lu && hz_if.id_halt) halt_m = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        hz_if.id_rs1 = 4'd0;           hz_if.id_rs2 = 4'd0;
        hz_if.id_use_rs1 = 1'b0;       hz_if.id_use_rs2 = 1'b0;
        hz_if.id_halt = 1'b0;          hz_if.idex_mem_read = 1'b0;
        hz_if.idex_rd = 4'd0;          hz_if.idex_mul_start = 1'b0;
        hz_if.idex_div_start = 1'b0;   hz_if.ex_branch_taken = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        idle_inputs();
        do_reset();
        lit("reset_stall_count", hz_if.stall_count, 16'd0);
        lit("reset_pc_write", {15'd0, hz_if.pc_write}, 16'd1);
        lit("reset_idex_write", {15'd0, hz_if.idex_write}, 16'd1);
        lit("reset_halted", {15'd0, hz_if.halted}, 16'd0);

        // Load r3 in EX, ID reads r3 via rs2.
        hz_if.idex_mem_read = 1'b1; hz_if.idex_rd = 4'd3;
        hz_if.id_rs2 = 4'd3; hz_if.id_use_rs2 = 1'b1; hz_if.id_rs1 = 4'd7; hz_if.id_use_rs1 = 1'b1;
        #1;
        lit("lu_pc_write", {15'd0, hz_if.pc_write}, 16'd0);
        lit("lu_idex_flush", {15'd0, hz_if.idex_flush}, 16'd1);
        tick();
        idle_inputs(); #1;
        lit("lu_stall_count", hz_if.stall_count, 16'd1);
        lit("lu_after_pc_write", {15'd0, hz_if.pc_write}, 16'd1);
        tick();

        // Load to r0 must not stall.
        do_reset();
        hz_if.idex_mem_read = 1'b1; hz_if.idex_rd = 4'd0;
        hz_if.id_rs1 = 4'd0; hz_if.id_use_rs1 = 1'b1; hz_if.id_use_rs2 = 1'b1;
        #1;
        lit("r0_pc_write", {15'd0, hz_if.pc_write}, 16'd1);
        tick();
        idle_inputs(); #1;
        lit("r0_stall_count", hz_if.stall_count, 16'd0);
        tick();

        // Multiply: T..T+2 stalled, done at T+2, RUN at T+3.
        do_reset();
        hz_if.idex_mul_start = 1'b1; #1;
        lit("mul_T_busy", {15'd0, hz_if.mdu_busy}, 16'd1);
        lit("mul_T_done", {15'd0, hz_if.mdu_done}, 16'd0);
        tick();
        idle_inputs(); #1;
        lit("mul_T1_done", {15'd0, hz_if.mdu_done}, 16'd0);
        tick(); #1;
        lit("mul_T2_done", {15'd0, hz_if.mdu_done}, 16'd1);
        lit("mul_T2_bubble", {15'd0, hz_if.exmem_bubble}, 16'd0);
        tick(); #1;
        lit("mul_T3_busy", {15'd0, hz_if.mdu_busy}, 16'd0);
        lit("mul_T3_pc_write", {15'd0, hz_if.pc_write}, 16'd1);
        lit("mul_stall_count", hz_if.stall_count, 16'd3);
        tick();

        // Divide with branch and load-use in the same cycle: divide wins.
        do_reset();
        hz_if.idex_div_start = 1'b1; hz_if.ex_branch_taken = 1'b1;
        hz_if.idex_mem_read = 1'b1; hz_if.idex_rd = 4'd5; hz_if.id_rs1 = 4'd5; hz_if.id_use_rs1 = 1'b1;
        #1;
        lit("div_ifid_flush", {15'd0, hz_if.ifid_flush}, 16'd0);
        lit("div_idex_flush", {15'd0, hz_if.idex_flush}, 16'd0);
        lit("div_busy", {15'd0, hz_if.mdu_busy}, 16'd1);
        tick();
        idle_inputs();
        for (int i = 0; i < DIV_N - 1; i++) tick();
        #1;
        lit("div_stall_count", hz_if.stall_count, 16'd8);
        lit("div_after_busy", {15'd0, hz_if.mdu_busy}, 16'd0);
        tick();

        // Mul and div together take the divide length.
        do_reset();
        hz_if.idex_mul_start = 1'b1; hz_if.idex_div_start = 1'b1;
        tick();
        idle_inputs();
        for (int i = 0; i < DIV_N - 1; i++) tick();
        #1;
        lit("muldiv_stall_count", hz_if.stall_count, 16'd8);
        tick();

        // Branch with id_halt: flush only; next-cycle id_halt alone halts.
        do_reset();
        hz_if.ex_branch_taken = 1'b1; hz_if.id_halt = 1'b1; #1;
        lit("br_ifid_flush", {15'd0, hz_if.ifid_flush}, 16'd1);
        lit("br_idex_flush", {15'd0, hz_if.idex_flush}, 16'd1);
        tick();
        hz_if.ex_branch_taken = 1'b0; #1;
        lit("br_halted_after", {15'd0, hz_if.halted}, 16'd0);
        lit("halt_issue_pc", {15'd0, hz_if.pc_write}, 16'd1);
        tick();
        idle_inputs(); #1;
        lit("halt_halted", {15'd0, hz_if.halted}, 16'd1);
        lit("halt_pc_write", {15'd0, hz_if.pc_write}, 16'd0);
        hz_if.idex_mul_start = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        #1;
        lit("halt_sticky", {15'd0, hz_if.halted}, 16'd1);
        lit("halt_no_count", hz_if.stall_count, 16'd0);
        tick();

        // Reset during the second MDU_BUSY cycle.
        do_reset();
        hz_if.idex_div_start = 1'b1;
        tick();
        idle_inputs();
        rst = 1'b1; #1;
        lit("rstmdu_done", {15'd0, hz_if.mdu_done}, 16'd0);
        tick();
        rst = 1'b0; #1;
        lit("rstmdu_busy", {15'd0, hz_if.mdu_busy}, 16'd0);
        lit("rstmdu_pc_write", {15'd0, hz_if.pc_write}, 16'd1);
        lit("rstmdu_stall_count", hz_if.stall_count, 16'd0);
        tick();

        // Saturation: hold a load-use hazard past 65535 cycles.
        do_reset();
        hz_if.idex_mem_read = 1'b1; hz_if.idex_rd = 4'd9; hz_if.id_rs1 = 4'd9; hz_if.id_use_rs1 = 1'b1;
        for (int i = 0; i < 65540; i++) tick();
        #1;
        lit("sat_stall_count", hz_if.stall_count, 16'hFFFF);
        tick();
        idle_inputs();
        tick(); #1;
        lit("sat_hold", hz_if.stall_count, 16'hFFFF);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
